insn_encoder: RTL and testbench

- Inverse of the core's instruction decoder. Takes operation/field bundles over a valid/ready handshake, assembles them into 32-bit A64 words, and streams them into instruction memory at sequential addresses.
- Used for bench program loading and boot-time program generation.
- A program ends when HLT is written. The block then signals done until the next start.

---
 rtl/insn_encoder_if.sv | 26 ++
 rtl/insn_encoder.sv | 130 +++++++++++++
 tb/tb_insn_encoder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/insn_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of the instruction encoder.
// The encoder connects through the slave modport and its environment through master.
interface insn_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_sel;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic [1:0]  hw;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;

    modport master (
        output in_valid, op_sel, rd, rn, rm, imm, hw, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, op_sel, rd, rn, rm, imm, hw, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/insn_encoder.sv
// Assembles operation/field bundles into 32-bit A64 words and streams them into
// instruction memory at sequential addresses until HLT is written.
module insn_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    insn_encoder_if.slave     bus,
    output logic [15:0]       word_count,
    output logic              done,
    output logic              err
);
    localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;
    typedef enum logic [2:0] {
        OP_HLT, OP_CBZ, OP_B, OP_MOVZ, OP_SUBI, OP_ADDI, OP_CMP, OP_ILL
    } opT;

    stateT       state;
    stateT       nextState;
    logic        weReg;
    logic [63:0] addrReg;
    logic [31:0] wdataReg;
    logic [15:0] countReg;
    logic        doneReg;
    logic        errReg;

    logic        accept;
    logic        drainNow;
    logic        illegal;
    logic        overflow;
    logic        loadWord;
    logic [63:0] targetAddr;
    opT          op;

    function automatic logic [31:0] encode(input opT o, input logic [4:0] rdF,
                                           input logic [4:0] rnF, input logic [4:0] rmF,
                                           input logic [25:0] immF, input logic [1:0] hwF);
        case (o)
            OP_HLT:  return 32'hD440_0000 | {11'b0, immF[15:0], 5'b0};
            OP_CBZ:  return 32'hB400_0000 | {8'b0, immF[18:0], rdF};
            OP_B:    return 32'h1400_0000 | {6'b0, immF[25:0]};
            OP_MOVZ: return 32'hD280_0000 | {9'b0, hwF, immF[15:0], rdF};
            OP_SUBI: return 32'hD100_0000 | {9'b0, hwF[0], immF[11:0], rnF, rdF};
            OP_ADDI: return 32'h9100_0000 | {9'b0, hwF[0], immF[11:0], rnF, rdF};
            OP_CMP:  return 32'hEB00_001F | {8'b0, hwF, 1'b0, rmF, immF[5:0], rnF, 5'b0};
            default: return 32'h0;
        endcase
    endfunction

    assign op       = opT'(bus.op_sel);
    assign accept   = bus.in_valid & bus.in_ready;
    assign drainNow = weReg & bus.imem_ready;
    // A bundle accepted while a word drains lands one slot past the draining word.
    assign targetAddr = weReg ? addrReg + 64'd4 : addrReg;
    assign illegal  = accept & (op == OP_ILL);
    assign overflow = accept & ~illegal & (targetAddr >= LIMIT_ADDR);
    assign loadWord = accept & ~illegal & ~overflow;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        nextState = state;
        if (start) begin
            nextState = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (overflow)                        nextState = DONE;
                    else if (loadWord && op == OP_HLT)   nextState = DRAIN;
                end
                DRAIN:   if (drainNow) nextState = DONE;
                default: nextState = state;
            endcase
        end
    end

    // start wins over a same-cycle handshake, so the bundle is never accepted.
    always_comb begin
        bus.in_ready = 1'b0;
        if (state == RUN && !start) bus.in_ready = ~weReg | bus.imem_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weReg    <= 1'b0;
            addrReg  <= BASE_ADDR;
            wdataReg <= 32'h0;
            countReg <= 16'h0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else if (start) begin
            weReg    <= 1'b0;
            addrReg  <= BASE_ADDR;
            countReg <= 16'h0;
            doneReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            if (drainNow) begin
                addrReg  <= addrReg + 64'd4;
                countReg <= countReg + 16'd1;
                if (state == DRAIN) doneReg <= 1'b1;
            end
            if (loadWord) begin
                weReg    <= 1'b1;
                wdataReg <= encode(op, bus.rd, bus.rn, bus.rm, bus.imm, bus.hw);
            end else if (drainNow) begin
                weReg <= 1'b0;
            end
            if (illegal || overflow) errReg <= 1'b1;
        end
    end

    assign bus.imem_we    = weReg;
    assign bus.imem_addr  = addrReg;
    assign bus.imem_wdata = wdataReg;
    assign word_count     = countReg;
    assign done           = doneReg;
    assign err            = errReg;
endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder: a full-size instance at address 0 and a two-word
// instance at 0x1000 share one stimulus stream; completed writes are logged per instance.
module tb_insn_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] countA, countB;
    logic        doneA, doneB, errA, errB;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wrT;
    wrT wrA[$];
    wrT wrB[$];

    insn_encoder_if a();
    insn_encoder_if b();

    assign b.in_valid   = a.in_valid;
    assign b.op_sel     = a.op_sel;
    assign b.rd         = a.rd;
    assign b.rn         = a.rn;
    assign b.rm         = a.rm;
    assign b.imm        = a.imm;
    assign b.hw         = a.hw;
    assign b.imem_ready = a.imem_ready;

    insn_encoder u_dutA (
        .clk(clk), .rst(rst), .start(start), .bus(a),
        .word_count(countA), .done(doneA), .err(errA)
    );

    insn_encoder #(.BASE_ADDR(64'h1000), .DEPTH(2)) u_dutB (
        .clk(clk), .rst(rst), .start(start), .bus(b),
        .word_count(countB), .done(doneB), .err(errB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a.imem_we && a.imem_ready) wrA.push_back({a.imem_addr, a.imem_wdata});
        if (b.imem_we && b.imem_ready) wrB.push_back({b.imem_addr, b.imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkWr(input string tag, input wrT q[$], input int idx,
                           input logic [63:0] addr, input logic [31:0] data);
        wrT e = '1;
        if (idx < q.size()) e = q[idx];
        check({tag, "_addr"}, e.addr, addr);
        check({tag, "_data"}, {32'h0, e.data}, {32'h0, data});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] opV, input logic [4:0] rdV, input logic [4:0] rnV,
                        input logic [4:0] rmV, input logic [25:0] immV, input logic [1:0] hwV);
        int waitCycles = 0;
        a.op_sel = opV; a.rd = rdV; a.rn = rnV; a.rm = rmV; a.imm = immV; a.hw = hwV;
        a.in_valid = 1'b1;
        #1;
        while (!a.in_ready && waitCycles < 20) begin
            @(posedge clk);
            #2;
            waitCycles++;
        end
        check("send_accept", {63'h0, a.in_ready}, 64'h1);
        tick();
        a.in_valid = 1'b0;
    endtask

    initial begin
        a.in_valid = 1'b0; a.op_sel = 3'd0; a.rd = 5'd0; a.rn = 5'd0; a.rm = 5'd0;
        a.imm = 26'd0; a.hw = 2'd0; a.imem_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", {63'h0, a.in_ready}, 64'h0);
        check("rst_we", {63'h0, a.imem_we}, 64'h0);
        check("rst_addr", a.imem_addr, 64'h0);
        check("rst_addr_b", b.imem_addr, 64'h1000);
        check("rst_wdata", {32'h0, a.imem_wdata}, 64'h0);
        check("rst_count", {48'h0, countA}, 64'h0);
        check("rst_done_err", {62'h0, doneA, errA}, 64'h0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", {63'h0, a.in_ready}, 64'h0);

        // MOVZ, ADDI, HLT program
        pulseStart();
        wrA.delete();
        send(3'd3, 5'd1, 5'd0, 5'd0, 26'd5, 2'd0);
        check("lat_we", {63'h0, a.imem_we}, 64'h1);
        check("lat_wdata", {32'h0, a.imem_wdata}, 64'hD28000A1);
        check("lat_addr", a.imem_addr, 64'h0);
        send(3'd5, 5'd2, 5'd1, 5'd0, 26'd3, 2'd0);
        send(3'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0);
        check("drain_in_ready", {63'h0, a.in_ready}, 64'h0);
        tick();
        tick();
        check("prog_n", 64'(wrA.size()), 64'd3);
        checkWr("prog_w0", wrA, 0, 64'h0, 32'hD28000A1);
        checkWr("prog_w1", wrA, 1, 64'h4, 32'h91000C22);
        checkWr("prog_w2", wrA, 2, 64'h8, 32'hD4400000);
        check("prog_done", {63'h0, doneA}, 64'h1);
        check("prog_count", {48'h0, countA}, 64'd3);
        check("prog_done_in_ready", {63'h0, a.in_ready}, 64'h0);

        // Negative branch offsets
        pulseStart();
        check("start_clears_done", {63'h0, doneA}, 64'h0);
        wrA.delete();
        send(3'd1, 5'd3, 5'd0, 5'd0, 26'h3FFFFFE, 2'd0);
        send(3'd2, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0);
        tick();
        check("br_n", 64'(wrA.size()), 64'd2);
        checkWr("br_cbz", wrA, 0, 64'h0, 32'hB4FFFFC3);
        checkWr("br_b", wrA, 1, 64'h4, 32'h17FFFFFF);

        // CMP with a three-cycle memory stall
        pulseStart();
        wrA.delete();
        a.imem_ready = 1'b0;
        send(3'd6, 5'd0, 5'd4, 5'd5, 26'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                a.imem_ready = 1'b1;
                #1;
            end
            check("stall_we", {63'h0, a.imem_we}, 64'h1);
            check("stall_wdata", {32'h0, a.imem_wdata}, 64'hEB05009F);
            if (i < 3) check("stall_in_ready", {63'h0, a.in_ready}, 64'h0);
            tick();
        end
        check("stall_n", 64'(wrA.size()), 64'd1);
        check("stall_count", {48'h0, countA}, 64'd1);
        check("stall_we_after", {63'h0, a.imem_we}, 64'h0);

        // Illegal op between two valid ops
        pulseStart();
        wrA.delete();
        send(3'd3, 5'd1, 5'd0, 5'd0, 26'd5, 2'd0);
        send(3'd7, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0);
        check("ill_err", {63'h0, errA}, 64'h1);
        check("ill_no_write", {63'h0, a.imem_we}, 64'h0);
        send(3'd5, 5'd2, 5'd1, 5'd0, 26'd3, 2'd0);
        tick();
        check("ill_n", 64'(wrA.size()), 64'd2);
        checkWr("ill_w0", wrA, 0, 64'h0, 32'hD28000A1);
        checkWr("ill_w1", wrA, 1, 64'h4, 32'h91000C22);

        // start aborts a pending write
        a.imem_ready = 1'b0;
        send(3'd3, 5'd7, 5'd0, 5'd0, 26'd0, 2'd0);
        check("abort_pending", {63'h0, a.imem_we}, 64'h1);
        pulseStart();
        check("abort_we", {63'h0, a.imem_we}, 64'h0);
        check("abort_addr", a.imem_addr, 64'h0);
        check("abort_count0", {48'h0, countA}, 64'd0);
        check("abort_err", {63'h0, errA}, 64'h0);
        a.imem_ready = 1'b1;
        wrA.delete();
        send(3'd3, 5'd1, 5'd0, 5'd0, 26'd5, 2'd0);
        tick();
        checkWr("abort_w0", wrA, 0, 64'h0, 32'hD28000A1);
        check("abort_count1", {48'h0, countA}, 64'd1);

        // start beats a same-cycle handshake
        pulseStart();
        wrA.delete();
        a.op_sel = 3'd2; a.imm = 26'd1; a.in_valid = 1'b1; start = 1'b1;
        #1;
        check("prio_in_ready", {63'h0, a.in_ready}, 64'h0);
        tick();
        start = 1'b0; a.in_valid = 1'b0;
        check("prio_we", {63'h0, a.imem_we}, 64'h0);
        tick();
        check("prio_n", 64'(wrA.size()), 64'd0);

        // Capacity: two-word instance sees three MOVZ
        pulseStart();
        wrB.delete();
        send(3'd3, 5'd1, 5'd0, 5'd0, 26'd1, 2'd0);
        send(3'd3, 5'd2, 5'd0, 5'd0, 26'd1, 2'd0);
        send(3'd3, 5'd3, 5'd0, 5'd0, 26'd1, 2'd0);
        tick();
        check("cap_n", 64'(wrB.size()), 64'd2);
        checkWr("cap_w0", wrB, 0, 64'h1000, 32'hD2800021);
        checkWr("cap_w1", wrB, 1, 64'h1004, 32'hD2800022);
        check("cap_err", {63'h0, errB}, 64'h1);
        check("cap_done", {63'h0, doneB}, 64'h0);
        check("cap_in_ready", {63'h0, b.in_ready}, 64'h0);
        check("cap_count", {48'h0, countB}, 64'd2);
        check("cap_big_count", {48'h0, countA}, 64'd3);

        // rst during a stalled write
        a.imem_ready = 1'b0;
        send(3'd3, 5'd4, 5'd0, 5'd0, 26'd2, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_we", {63'h0, a.imem_we}, 64'h0);
        check("rstw_count", {48'h0, countA}, 64'd0);
        check("rstw_in_ready", {63'h0, a.in_ready}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
